// File: rtl/fp_iter_sched.sv
// -----------------------------------------------------------------------------
// fp_iter_sched
//
// Scheduler for the single shared iterative divide / square-root unit of the
// pipelined FPU. It accepts div.s / sqrt.s issues from ID, launches the
// iterative unit, counts its latency down, scoreboards the one pending
// destination register, and hands the result to the FPR write slot only in a
// cycle where the pipelined e3 path leaves that slot free.
//
// Ports
//   clock        in   1  rising-edge clock
//   reset        in   1  asynchronous reset, active-high
//   iss_valid    in   1  ID holds an FP instruction this cycle
//   iss_fc       in   3  FP function code (011 = div, 100 = sqrt, else pipelined)
//   iss_fs       in   5  source register fs
//   iss_ft       in   5  source register ft
//   iss_fd       in   5  destination register fd
//   iss_use_fs   in   1  instruction reads fs
//   iss_use_ft   in   1  instruction reads ft
//   pipe_stall   in   1  another stall source holds ID (blocks accept only)
//   slot_busy    in   1  e3 writes the FPR file next cycle
//   stall        out  1  hold ID because of this scheduler
//   start        out  1  one-cycle launch pulse to the iterative unit
//   op_sqrt      out  1  latched operation, 1 = sqrt
//   busy         out  1  iterative unit occupied (RUN or HOLD)
//   count        out  5  cycles remaining in RUN
//   done         out  1  iterative result is written this cycle
//   done_fd      out  5  destination register for done (0 when idle)
//   fwd_done     out  1  select the iterative result on the ID forwarding mux
//                        (only when FPSCHED_DONE_FWD_EN is defined)
//
// Configuration macro
//   FPSCHED_DONE_FWD_EN  when defined, a read-after-write hit against the
//                        pending register is resolved by forwarding in the
//                        done cycle instead of stalling; write-after-write
//                        hits still stall. When undefined, the fwd_done port
//                        does not exist and any hit stalls through done.
//
// Parameters
//   DIV_CYCLES   divide latency from start to done, 2..31
//   SQRT_CYCLES  square-root latency from start to done, 2..31
// -----------------------------------------------------------------------------
module fp_iter_sched #(
  parameter int unsigned DIV_CYCLES  = 16,
  parameter int unsigned SQRT_CYCLES = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iss_valid,
  input  logic [2:0] iss_fc,
  input  logic [4:0] iss_fs,
  input  logic [4:0] iss_ft,
  input  logic [4:0] iss_fd,
  input  logic       iss_use_fs,
  input  logic       iss_use_ft,
  input  logic       pipe_stall,
  input  logic       slot_busy,
  output logic       stall,
  output logic       start,
  output logic       op_sqrt,
  output logic       busy,
  output logic [4:0] count,
  output logic       done,
  output logic [4:0] done_fd
`ifdef FPSCHED_DONE_FWD_EN
  ,
  output logic       fwd_done
`endif
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [2:0] FC_DIV  = 3'b011;
  localparam logic [2:0] FC_SQRT = 3'b100;

  // The counter is loaded with LAT-1 on accept: the accept cycle itself is the
  // first latency cycle, so count reaches 0 exactly LAT cycles after start.
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);
  localparam logic [4:0] SQRT_LOAD = 5'(SQRT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0] state_q,   state_d;
  logic [4:0] count_q,   count_d;
  logic [4:0] pend_fd_q, pend_fd_d;
  logic       op_sqrt_q, op_sqrt_d;

  // ---------------------------------------------------------------------------
  // Issue decode and hazard detection
  // ---------------------------------------------------------------------------
  logic is_iter;
  logic fs_match;
  logic ft_match;
  logic fd_match;
  logic raw_match;
  logic waw_match;
  logic hit_stall;
  logic count_zero;
  logic slot_free;
  logic accept;

  assign is_iter = (iss_fc == FC_DIV) || (iss_fc == FC_SQRT);

  // Register 0 is an ordinary FPR, so no zero-register exemption here.
  assign fs_match = iss_use_fs && (iss_fs == pend_fd_q);
  assign ft_match = iss_use_ft && (iss_ft == pend_fd_q);
  assign fd_match = (iss_fd == pend_fd_q);

  // pend_fd_q keeps its last value after completion, so every match is
  // qualified by busy to avoid phantom hazards against a retired result.
  assign raw_match = busy && (fs_match || ft_match);
  assign waw_match = busy && fd_match;

  assign count_zero = (count_q == 5'd0);
  assign slot_free  = ~slot_busy;

  // The result leaves either at the end of RUN or from HOLD, and in both cases
  // only when e3 is not claiming the write port.
  assign done = (((state_q == ST_RUN) && count_zero) || (state_q == ST_HOLD))
                && slot_free;

`ifdef FPSCHED_DONE_FWD_EN
  // In the done cycle the result is on the forwarding path, so a reader can
  // proceed; a second writer to the same register must still wait so the
  // write order to the FPR file is preserved.
  assign hit_stall = waw_match || (raw_match && ~done);
  assign fwd_done  = iss_valid && done && raw_match;
`else
  assign hit_stall = raw_match || waw_match;
`endif

  // A second iterative op cannot use the unit while it is occupied, including
  // the done cycle itself; the earliest back-to-back start is the cycle after.
  assign stall = iss_valid && ((is_iter && busy) || hit_stall);

  // pipe_stall only blocks the launch; it never freezes an operation in flight.
  assign accept = iss_valid && is_iter && ~stall && ~pipe_stall
                  && (state_q == ST_IDLE);

  // start is combinational from the inputs, so it is masked while reset is
  // held to keep every output quiet during reset.
  assign start = accept && ~reset;

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  assign busy    = (state_q != ST_IDLE);
  assign count   = count_q;
  assign op_sqrt = op_sqrt_q;
  assign done_fd = busy ? pend_fd_q : 5'd0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a hold-value default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pend_fd_d = pend_fd_q;
    op_sqrt_d = op_sqrt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_RUN;
          pend_fd_d = iss_fd;
          op_sqrt_d = (iss_fc == FC_SQRT);
          count_d   = (iss_fc == FC_SQRT) ? SQRT_LOAD : DIV_LOAD;
        end
      end

      ST_RUN: begin
        if (count_zero) begin
          // Result is ready; park in HOLD if e3 owns the write slot.
          state_d = slot_free ? ST_IDLE : ST_HOLD;
        end else begin
          count_d = count_q - 5'd1;
        end
      end

      ST_HOLD: begin
        // count stays at 0 here; wait as long as e3 keeps the slot.
        if (slot_free) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others regardless of statement order. Reset is
  // asynchronous: asserting it mid-operation abandons the result with no done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= 5'd0;
      pend_fd_q <= 5'd0;
      op_sqrt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pend_fd_q <= pend_fd_d;
      op_sqrt_q <= op_sqrt_d;
    end
  end

endmodule
